// File: rtl/hazard_sequencer_pkg.sv
// Shared definitions for the hazard sequencer: controller state encoding and
// layout of the in-flight write shadow.
package hazard_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } state_e;

    localparam int unsigned SHADOW_DEPTH = 3;
    localparam int unsigned SH_EX        = 0;
    localparam int unsigned SH_MEM       = 1;
    localparam int unsigned SH_WB        = 2;

endpackage

// File: rtl/hazard_shadow.sv
// Three-entry shadow of register writes in flight (EX, MEM, WB) with
// per-stage source-operand match against the instruction in ID.
module hazard_shadow
    import hazard_sequencer_pkg::*;
#(
    parameter int unsigned REG_W = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_push_valid,
    input  logic [REG_W-1:0]        i_push_dest,
    input  logic                    i_push_load,
    input  logic [REG_W-1:0]        i_rs,
    input  logic [REG_W-1:0]        i_rt,
    input  logic                    i_uses_rs,
    input  logic                    i_uses_rt,
    output logic [SHADOW_DEPTH-1:0] o_hit,
    output logic [SHADOW_DEPTH-1:0] o_valid,
    output logic                    o_ex_load
);

    logic [SHADOW_DEPTH-1:0] r_valid;
    logic [SHADOW_DEPTH-1:0] r_load;
    logic [REG_W-1:0]        r_dest [SHADOW_DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_load  <= '0;
            for (int unsigned i = 0; i < SHADOW_DEPTH; i++) begin
                r_dest[i] <= '0;
            end
        end else begin
            r_valid[SH_WB]  <= r_valid[SH_MEM];
            r_load[SH_WB]   <= r_load[SH_MEM];
            r_dest[SH_WB]   <= r_dest[SH_MEM];
            r_valid[SH_MEM] <= r_valid[SH_EX];
            r_load[SH_MEM]  <= r_load[SH_EX];
            r_dest[SH_MEM]  <= r_dest[SH_EX];
            r_valid[SH_EX]  <= i_push_valid;
            r_load[SH_EX]   <= i_push_load;
            r_dest[SH_EX]   <= i_push_dest;
        end
    end

    always_comb begin
        o_hit = '0;
        for (int unsigned i = 0; i < SHADOW_DEPTH; i++) begin
            o_hit[i] = r_valid[i] & ((i_uses_rs & (i_rs == r_dest[i])) |
                                     (i_uses_rt & (i_rt == r_dest[i])));
        end
    end

    assign o_valid   = r_valid;
    assign o_ex_load = r_load[SH_EX];

endmodule

// File: rtl/hazard_sequencer.sv
// Run/stall/flush controller for the 5-stage pipeline: start/halt sequencing,
// load-use / RAW stall detection, branch flush and a saturating stall counter.
module hazard_sequencer
    import hazard_sequencer_pkg::*;
#(
    parameter int unsigned REG_W      = 5,
    parameter int unsigned FORWARDING = 1,
    parameter int unsigned WB_BYPASS  = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             halt_req,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_reg_write,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_mem_read,
    input  logic             ex_branch_taken,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic             flush_if_id,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count
);

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [CNT_W-1:0]        r_stall_cnt;
    logic [SHADOW_DEPTH-1:0] w_hit;
    logic [SHADOW_DEPTH-1:0] w_valid;
    logic                    w_ex_load;
    logic                    w_hazard;
    logic                    w_push_valid;
    logic                    w_count_stall;
    logic                    w_start_ok;

    assign w_push_valid = id_valid & id_reg_write & (id_dest != '0) & ~id_ex_bubble;

    hazard_shadow #(
        .REG_W(REG_W)
    ) u_shadow (
        .clk         (clk),
        .rst         (rst),
        .i_push_valid(w_push_valid),
        .i_push_dest (id_dest),
        .i_push_load (id_mem_read),
        .i_rs        (id_rs),
        .i_rt        (id_rt),
        .i_uses_rs   (id_uses_rs),
        .i_uses_rt   (id_uses_rt),
        .o_hit       (w_hit),
        .o_valid     (w_valid),
        .o_ex_load   (w_ex_load)
    );

    always_comb begin
        if (FORWARDING != 0) begin
            w_hazard = w_hit[SH_EX] & w_ex_load;
        end else begin
            w_hazard = w_hit[SH_EX] | w_hit[SH_MEM] | ((WB_BYPASS == 0) & w_hit[SH_WB]);
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
        flush_if_id  = 1'b0;
        case (r_state)
            ST_IDLE, ST_HALTED: begin
                if (start) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                pc_write     = 1'b1;
                if_id_write  = 1'b1;
                id_ex_bubble = 1'b0;
                // A taken branch squashes the ID instruction, so any stall it would cause is moot.
                if (ex_branch_taken) begin
                    flush_if_id  = 1'b1;
                    id_ex_bubble = 1'b1;
                end else if (id_valid & w_hazard) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                end
                if (halt_req) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (~|w_valid) w_state_nxt = ST_HALTED;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_count_stall = (r_state == ST_RUN) & ~ex_branch_taken & id_valid & w_hazard;
    assign w_start_ok    = start & ((r_state == ST_IDLE) | (r_state == ST_HALTED));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_ok) begin
                r_stall_cnt <= '0;
            end else if (w_count_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign running     = (r_state == ST_RUN);
    assign halted      = (r_state == ST_HALTED);
    assign stall_count = r_stall_cnt;

endmodule
